// File: rtl/esc_mode_controller.sv
`default_nettype none
// ============================================================================
// Module   : esc_mode_controller
// Purpose  : Escape-mode front end for the C-PHY master LP transmitter.
//            Runs the escape entry sequence, fetches the 8-bit escape
//            command from the downstream sequencer, sends it spaced-one-hot,
//            then serialises LPDT bytes, parks in ULPS or exits to Stop.
// Revision : 1.0 - initial release
// ============================================================================
module esc_mode_controller #(
  parameter int TLPX_CYC    = 1,
  parameter int TWAKEUP_CYC = 16
) (
  input  logic       TxClkEsc,
  input  logic       RstN,
  input  logic       TxRequestEsc,
  input  logic       TxLpdtEsc,
  input  logic       TxUlpsEsc,
  input  logic [3:0] TxTriggerEsc,
  input  logic       TxUlpsExit,
  input  logic [7:0] TxDataEsc,
  input  logic       TxValidEsc,
  output logic       TxReadyEsc,
  input  logic       SeqBit,
  input  logic       CmdDone,
  output logic [7:0] EscSeqCtr,
  output logic [1:0] LpState,
  output logic       EscBusy,
  output logic       UlpsActiveNot,
  output logic       CmdErr
);

  // One shared down-time counter covers line-state timing, the 9-cycle
  // command fetch and the wake-up interval, so size it for the longest.
  localparam int MAX_AB  = (TLPX_CYC > TWAKEUP_CYC) ? TLPX_CYC : TWAKEUP_CYC;
  localparam int CNT_MAX = (MAX_AB > 9) ? MAX_AB : 9;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] TLPX_LAST  = CNT_W'(TLPX_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(TWAKEUP_CYC - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] LP_STOP  = 2'b11;
  localparam logic [1:0] LP_MARK1 = 2'b10;
  localparam logic [1:0] LP_MARK0 = 2'b01;
  localparam logic [1:0] LP_SPACE = 2'b00;

  typedef enum logic [3:0] {
    ST_STOP,
    ST_ENTRY,
    ST_FETCH,
    ST_CMD_TX,
    ST_LPDT_WAIT,
    ST_LPDT_TX,
    ST_ULPS,
    ST_WAKEUP,
    ST_EXIT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;         // entry step or bit index
  logic             phase, phase_n;     // 0 = mark, 1 = space
  logic [5:0]       sel, sel_n;         // latched one-hot mode
  logic [7:0]       tx_reg, tx_n;       // command / payload shift register
  logic             done_seen, done_seen_n;

  logic [1:0]       lp_state, lp_n;
  logic [5:0]       seq_ctr, ctr_n;
  logic             tx_ready, ready_n;
  logic             esc_busy, busy_n;
  logic             ulps_not, ulps_n;
  logic             cmd_err, err_n;

  logic [5:0]       mode_req;

  // Spaced-one-hot mark for one data bit.
  function automatic logic [1:0] mark_of(input logic b);
    return b ? LP_MARK1 : LP_MARK0;
  endfunction

  // Line pattern of the four escape entry steps.
  function automatic logic [1:0] entry_line(input logic [1:0] step);
    logic [1:0] v;
    case (step)
      2'd0:    v = LP_MARK1;
      2'd1:    v = LP_SPACE;
      2'd2:    v = LP_MARK0;
      default: v = LP_SPACE;
    endcase
    return v;
  endfunction

  assign LpState       = lp_state;
  assign EscSeqCtr     = {2'b00, seq_ctr};
  assign TxReadyEsc    = tx_ready;
  assign EscBusy       = esc_busy;
  assign UlpsActiveNot = ulps_not;
  assign CmdErr        = cmd_err;

  // Priority-encode the requested mode: LPDT, ULPS, then triggers 0..3.
  always_comb begin
    mode_req = 6'b000000;
    if (TxLpdtEsc)            mode_req = 6'b000001;
    else if (TxUlpsEsc)       mode_req = 6'b000010;
    else if (TxTriggerEsc[0]) mode_req = 6'b000100;
    else if (TxTriggerEsc[1]) mode_req = 6'b001000;
    else if (TxTriggerEsc[2]) mode_req = 6'b010000;
    else if (TxTriggerEsc[3]) mode_req = 6'b100000;
  end

  // Next state and next registered outputs; outputs are computed one cycle
  // ahead so every port comes straight from a flop.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    phase_n     = phase;
    sel_n       = sel;
    tx_n        = tx_reg;
    done_seen_n = done_seen;
    lp_n        = lp_state;
    ctr_n       = seq_ctr;
    ready_n     = tx_ready;
    busy_n      = esc_busy;
    ulps_n      = ulps_not;
    err_n       = cmd_err;

    case (state)
      ST_STOP: begin
        if (TxRequestEsc && (mode_req != 6'b000000)) begin
          state_n = ST_ENTRY;
          sel_n   = mode_req;
          cnt_n   = '0;
          idx_n   = 3'd0;
          lp_n    = LP_MARK1;
          busy_n  = 1'b1;
        end
      end

      ST_ENTRY: begin
        if (cnt == TLPX_LAST) begin
          cnt_n = '0;
          if (idx == 3'd3) begin
            state_n     = ST_FETCH;
            idx_n       = 3'd0;
            done_seen_n = 1'b0;
            lp_n        = LP_SPACE;
            ctr_n       = sel;
          end else begin
            idx_n = idx + 3'd1;
            lp_n  = entry_line(idx[1:0] + 2'd1);
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      ST_FETCH: begin
        // Select is presented in cycle 0; bits arrive on the following 8 edges.
        if (cnt != '0) begin
          tx_n = {SeqBit, tx_reg[7:1]};
          if (CmdDone) done_seen_n = 1'b1;
        end
        if (cnt == FETCH_LAST) begin
          ctr_n   = 6'b000000;
          if (!(done_seen || CmdDone)) err_n = 1'b1;
          state_n = ST_CMD_TX;
          cnt_n   = '0;
          idx_n   = 3'd0;
          phase_n = 1'b0;
          lp_n    = mark_of(tx_n[0]);
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      ST_CMD_TX, ST_LPDT_TX: begin
        if (cnt == TLPX_LAST) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
            lp_n    = LP_SPACE;
          end else if (idx == 3'd7) begin
            phase_n = 1'b0;
            idx_n   = 3'd0;
            if (sel[0]) begin
              state_n = ST_LPDT_WAIT;
              lp_n    = LP_SPACE;
              ready_n = 1'b1;
            end else if (sel[1]) begin
              state_n = ST_ULPS;
              lp_n    = LP_SPACE;
              ulps_n  = 1'b0;
            end else begin
              state_n = ST_EXIT;
              lp_n    = LP_MARK1;
            end
          end else begin
            idx_n   = idx + 3'd1;
            phase_n = 1'b0;
            tx_n    = {1'b0, tx_reg[7:1]};
            lp_n    = mark_of(tx_reg[1]);
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      ST_LPDT_WAIT: begin
        // A dropped request wins over a simultaneous valid byte.
        if (!TxRequestEsc) begin
          state_n = ST_EXIT;
          ready_n = 1'b0;
          lp_n    = LP_MARK1;
          cnt_n   = '0;
        end else if (TxValidEsc) begin
          state_n = ST_LPDT_TX;
          ready_n = 1'b0;
          tx_n    = TxDataEsc;
          lp_n    = mark_of(TxDataEsc[0]);
          cnt_n   = '0;
          idx_n   = 3'd0;
          phase_n = 1'b0;
        end
      end

      ST_ULPS: begin
        if (TxUlpsExit) begin
          state_n = ST_WAKEUP;
          cnt_n   = '0;
          lp_n    = LP_MARK1;
        end
      end

      ST_WAKEUP: begin
        if (cnt == WAKE_LAST) begin
          state_n = ST_STOP;
          lp_n    = LP_STOP;
          ulps_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      ST_EXIT: begin
        if (cnt == TLPX_LAST) begin
          state_n = ST_STOP;
          lp_n    = LP_STOP;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = ST_STOP;
        lp_n    = LP_STOP;
        ctr_n   = 6'b000000;
        ready_n = 1'b0;
        busy_n  = 1'b0;
        ulps_n  = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset drops the line to Stop at once.
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) begin
      state     <= ST_STOP;
      cnt       <= '0;
      idx       <= 3'd0;
      phase     <= 1'b0;
      sel       <= 6'b000000;
      tx_reg    <= 8'h00;
      done_seen <= 1'b0;
      lp_state  <= LP_STOP;
      seq_ctr   <= 6'b000000;
      tx_ready  <= 1'b0;
      esc_busy  <= 1'b0;
      ulps_not  <= 1'b1;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      phase     <= phase_n;
      sel       <= sel_n;
      tx_reg    <= tx_n;
      done_seen <= done_seen_n;
      lp_state  <= lp_n;
      seq_ctr   <= ctr_n;
      tx_ready  <= ready_n;
      esc_busy  <= busy_n;
      ulps_not  <= ulps_n;
      cmd_err   <= err_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_esc_mode_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_esc_mode_controller
// Purpose  : Directed self-checking bench for esc_mode_controller with a
//            small behavioural model of the ESC command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esc_mode_controller;

  logic       TxClkEsc = 1'b0;
  logic       RstN = 1'b0;
  logic       TxRequestEsc = 1'b0;
  logic       TxLpdtEsc = 1'b0;
  logic       TxUlpsEsc = 1'b0;
  logic [3:0] TxTriggerEsc = 4'b0000;
  logic       TxUlpsExit = 1'b0;
  logic [7:0] TxDataEsc = 8'h00;
  logic       TxValidEsc = 1'b0;
  logic       TxReadyEsc;
  logic       SeqBit = 1'b0;
  logic       CmdDone = 1'b0;
  logic [7:0] EscSeqCtr;
  logic [1:0] LpState;
  logic       EscBusy;
  logic       UlpsActiveNot;
  logic       CmdErr;

  int total = 0;
  int bad   = 0;
  int hs    = 0;

  // Sequencer model: bits in arrival order, bit 0 arrives first.
  logic [7:0] seq_cmd     = 8'b0110_0011;
  logic       seq_done_en = 1'b1;
  int         seq_k       = 0;

  esc_mode_controller #(.TLPX_CYC(1), .TWAKEUP_CYC(16)) dut (
    .TxClkEsc      (TxClkEsc),
    .RstN          (RstN),
    .TxRequestEsc  (TxRequestEsc),
    .TxLpdtEsc     (TxLpdtEsc),
    .TxUlpsEsc     (TxUlpsEsc),
    .TxTriggerEsc  (TxTriggerEsc),
    .TxUlpsExit    (TxUlpsExit),
    .TxDataEsc     (TxDataEsc),
    .TxValidEsc    (TxValidEsc),
    .TxReadyEsc    (TxReadyEsc),
    .SeqBit        (SeqBit),
    .CmdDone       (CmdDone),
    .EscSeqCtr     (EscSeqCtr),
    .LpState       (LpState),
    .EscBusy       (EscBusy),
    .UlpsActiveNot (UlpsActiveNot),
    .CmdErr        (CmdErr)
  );

  always #5 TxClkEsc = ~TxClkEsc;

  // Sequencer: select seen in cycle k=0, bit k-1 driven in cycles 1..8,
  // CmdDone raised with the last bit when enabled.
  always @(negedge TxClkEsc) begin
    if (EscSeqCtr != 8'h00) begin
      if (seq_k >= 1 && seq_k <= 8) SeqBit = seq_cmd[seq_k-1];
      CmdDone = seq_done_en && (seq_k == 8);
      seq_k = seq_k + 1;
    end else begin
      seq_k   = 0;
      SeqBit  = 1'b0;
      CmdDone = 1'b0;
    end
  end

  // Count accepted LPDT bytes (a byte offered as the request drops is refused).
  always @(posedge TxClkEsc) begin
    if (TxValidEsc && TxReadyEsc && TxRequestEsc) hs = hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expect line value v with EscBusy high for n cycles.
  task automatic lines(input string tag, input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(LpState), 32'(v));
      chk({tag, "_busy"}, 32'(EscBusy), 32'd1);
      @(negedge TxClkEsc);
    end
  endtask

  // Expect a byte spaced-one-hot, LSB / first-arrived bit first.
  task automatic bits(input string tag, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      lines(tag, b[i] ? 2'b10 : 2'b01, 1);
      lines(tag, 2'b00, 1);
    end
  endtask

  task automatic start(input logic lpdt, input logic ulps, input logic [3:0] trig);
    TxRequestEsc = 1'b1;
    TxLpdtEsc    = lpdt;
    TxUlpsEsc    = ulps;
    TxTriggerEsc = trig;
    @(negedge TxClkEsc);
    TxLpdtEsc    = 1'b0;
    TxUlpsEsc    = 1'b0;
    TxTriggerEsc = 4'b0000;
    if (!lpdt) TxRequestEsc = 1'b0;
  endtask

  task automatic entry_fetch(input string tag, input logic [7:0] sel);
    lines({tag, "_e0"}, 2'b10, 1);
    lines({tag, "_e1"}, 2'b00, 1);
    lines({tag, "_e2"}, 2'b01, 1);
    lines({tag, "_e3"}, 2'b00, 1);
    for (int i = 0; i < 9; i++) begin
      chk({tag, "_sel"}, 32'(EscSeqCtr), 32'(sel));
      lines({tag, "_fetch"}, 2'b00, 1);
    end
    chk({tag, "_selclr"}, 32'(EscSeqCtr), 32'd0);
  endtask

  task automatic finish_exit(input string tag);
    lines({tag, "_exit"}, 2'b10, 1);
    chk({tag, "_stop"}, 32'(LpState), 32'd3);
    chk({tag, "_idle"}, 32'(EscBusy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset with a request pending.
    TxRequestEsc = 1'b1;
    TxLpdtEsc    = 1'b1;
    repeat (3) @(negedge TxClkEsc);
    chk("rst_lp",   32'(LpState),       32'd3);
    chk("rst_ctr",  32'(EscSeqCtr),     32'd0);
    chk("rst_busy", 32'(EscBusy),       32'd0);
    chk("rst_ulps", 32'(UlpsActiveNot), 32'd1);
    chk("rst_rdy",  32'(TxReadyEsc),    32'd0);
    chk("rst_err",  32'(CmdErr),        32'd0);
    TxRequestEsc = 1'b0;
    TxLpdtEsc    = 1'b0;
    RstN         = 1'b1;
    repeat (2) @(negedge TxClkEsc);

    // Request with no mode bit stays in Stop.
    TxRequestEsc = 1'b1;
    repeat (2) @(negedge TxClkEsc);
    chk("nomode_lp",   32'(LpState), 32'd3);
    chk("nomode_busy", 32'(EscBusy), 32'd0);
    TxRequestEsc = 1'b0;
    @(negedge TxClkEsc);

    // Trigger 0 beats trigger 2; 30 busy cycles then Stop.
    start(1'b0, 1'b0, 4'b0101);
    entry_fetch("trig", 8'h04);
    bits("trig_cmd", seq_cmd);
    finish_exit("trig");
    chk("trig_err", 32'(CmdErr), 32'd0);
    @(negedge TxClkEsc);

    // LPDT beats ULPS and triggers; two bytes then exit.
    start(1'b1, 1'b1, 4'b1111);
    entry_fetch("lpdt", 8'h01);
    bits("lpdt_cmd", seq_cmd);
    chk("lpdt_rdy1", 32'(TxReadyEsc), 32'd1);
    chk("lpdt_w1",   32'(LpState),    32'd0);
    TxDataEsc  = 8'hA5;
    TxValidEsc = 1'b1;
    @(negedge TxClkEsc);
    TxValidEsc = 1'b0;
    chk("lpdt_rdy_lo1", 32'(TxReadyEsc), 32'd0);
    bits("lpdt_a5", 8'hA5);
    chk("lpdt_rdy2", 32'(TxReadyEsc), 32'd1);
    lines("lpdt_w2", 2'b00, 2);
    chk("lpdt_rdy3", 32'(TxReadyEsc), 32'd1);
    TxDataEsc  = 8'h3C;
    TxValidEsc = 1'b1;
    @(negedge TxClkEsc);
    TxValidEsc = 1'b0;
    chk("lpdt_rdy_lo2", 32'(TxReadyEsc), 32'd0);
    bits("lpdt_3c", 8'h3C);
    chk("lpdt_rdy4", 32'(TxReadyEsc), 32'd1);
    TxRequestEsc = 1'b0;
    @(negedge TxClkEsc);
    chk("lpdt_rdy_end", 32'(TxReadyEsc), 32'd0);
    finish_exit("lpdt");
    chk("lpdt_hs", 32'(hs), 32'd2);
    @(negedge TxClkEsc);

    // Valid offered on the same edge the request drops: refused.
    start(1'b1, 1'b0, 4'b0000);
    entry_fetch("abort", 8'h01);
    bits("abort_cmd", seq_cmd);
    chk("abort_rdy", 32'(TxReadyEsc), 32'd1);
    TxRequestEsc = 1'b0;
    TxDataEsc    = 8'hFF;
    TxValidEsc   = 1'b1;
    @(negedge TxClkEsc);
    TxValidEsc = 1'b0;
    chk("abort_rdy_lo", 32'(TxReadyEsc), 32'd0);
    finish_exit("abort");
    chk("abort_hs", 32'(hs), 32'd2);
    @(negedge TxClkEsc);

    // ULPS exit pulse while in Stop is ignored.
    TxUlpsExit = 1'b1;
    @(negedge TxClkEsc);
    TxUlpsExit = 1'b0;
    chk("stopx_lp",   32'(LpState),       32'd3);
    chk("stopx_busy", 32'(EscBusy),       32'd0);
    chk("stopx_ulps", 32'(UlpsActiveNot), 32'd1);
    @(negedge TxClkEsc);

    // ULPS beats triggers; park, then 16-cycle wake-up.
    start(1'b0, 1'b1, 4'b0001);
    entry_fetch("ulps", 8'h02);
    bits("ulps_cmd", seq_cmd);
    for (int i = 0; i < 3; i++) begin
      chk("ulps_lp",  32'(LpState),       32'd0);
      chk("ulps_not", 32'(UlpsActiveNot), 32'd0);
      chk("ulps_busy", 32'(EscBusy),      32'd1);
      @(negedge TxClkEsc);
    end
    TxUlpsExit = 1'b1;
    @(negedge TxClkEsc);
    TxUlpsExit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("wake_lp",  32'(LpState),       32'd2);
      chk("wake_not", 32'(UlpsActiveNot), 32'd0);
      @(negedge TxClkEsc);
    end
    chk("wake_stop", 32'(LpState),       32'd3);
    chk("wake_not1", 32'(UlpsActiveNot), 32'd1);
    chk("wake_idle", 32'(EscBusy),       32'd0);
    @(negedge TxClkEsc);

    // Sequencer never signals done: sticky error, command still sent.
    seq_done_en = 1'b0;
    seq_cmd     = 8'b1011_0100;
    chk("err_pre", 32'(CmdErr), 32'd0);
    start(1'b0, 1'b0, 4'b1000);
    entry_fetch("err", 8'h20);
    chk("err_set", 32'(CmdErr), 32'd1);
    bits("err_cmd", seq_cmd);
    finish_exit("err");
    repeat (2) @(negedge TxClkEsc);
    chk("err_sticky", 32'(CmdErr), 32'd1);
    seq_done_en = 1'b1;

    // Reset asserted mid command transmit drops straight to Stop.
    start(1'b0, 1'b0, 4'b0010);
    entry_fetch("mid", 8'h08);
    lines("mid_cmd", (seq_cmd[0] ? 2'b10 : 2'b01), 1);
    lines("mid_cmd", 2'b00, 1);
    #2;
    RstN = 1'b0;
    #1;
    chk("mid_lp",   32'(LpState),       32'd3);
    chk("mid_busy", 32'(EscBusy),       32'd0);
    chk("mid_ctr",  32'(EscSeqCtr),     32'd0);
    chk("mid_err",  32'(CmdErr),        32'd0);
    chk("mid_ulps", 32'(UlpsActiveNot), 32'd1);
    @(negedge TxClkEsc);
    RstN = 1'b1;
    repeat (2) @(negedge TxClkEsc);
    chk("mid_after_lp",   32'(LpState), 32'd3);
    chk("mid_after_busy", 32'(EscBusy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
